branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Consumer end of the ALU result/flags interface. It takes the NZCV flags produced by the ALU on a SUB compare, plus branch metadata, and resolves the RISC-V conditional branch: taken/not-taken and target PC. It is a 2-stage valid/ready pipeline between the execute stage and the PC-select logic, with a flush input for redirects.

Parameters:
XLEN, 32, width of pc, imm and target
CNT_W, 16, width of the statistics counters (used only with BRU_STATS_EN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has a branch to resolve
in_ready  output  1  unit can accept this cycle
flags  input  4  ALU flags {N,Z,C,V}; bit3=N, bit2=Z, bit1=C, bit0=V, from a SUB of a-b
funct3  input  3  branch condition code
pc  input  XLEN  branch instruction PC
imm  input  XLEN  sign-extended branch offset
flush  input  1  synchronous kill of all in-flight entries
out_valid  output  1  resolved result available
out_ready  input  1  downstream accepts the result
taken  output  1  branch taken
target  output  XLEN  pc+imm when taken; pc+4 when not taken
illegal  output  1  funct3 is not a branch code
taken_cnt  output  CNT_W  taken branches retired (BRU_STATS_EN only)
total_cnt  output  CNT_W  all branches retired (BRU_STATS_EN only)

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, out_valid=0, taken=0, target=0, illegal=0, counters=0. Removing reset takes effect on the next clk edge only.
- Transfer rule: input fires when in_valid&&in_ready. Output fires when out_valid&&out_ready.
- Stage 1 registers flags, funct3, pc and imm on an input fire. Stage 2 (output register) computes taken, target and illegal from stage 1.
- Latency: an input accepted at edge k shows out_valid=1 after edge k+1. Throughput is 1 per cycle when out_ready=1.
- Advance: stage 2 loads when it is empty or firing. Stage 1 drains into stage 2 under the same condition.
- in_ready = !s1_valid || (s1 advancing). It is combinational and has no dependency on in_valid.
- Back-pressure: with out_ready=0, at most 2 entries are held. in_ready=0 when both stages are full. Order is preserved and no entry is lost or duplicated.
- Outputs are stable while out_valid=1 and out_ready=0.
- Conditions, taken when:
  - 000 BEQ: Z
  - 001 BNE: !Z
  - 100 BLT: N^V
  - 101 BGE: !(N^V)
  - 110 BLTU: !C
  - 111 BGEU: C
  - 010/011: taken=0, illegal=1, target=pc+4
- Carry convention: C=1 means no borrow, i.e. a>=b unsigned.
- Target arithmetic is modulo 2^XLEN and wraps silently; e.g. pc=0xFFFFFFF0 with imm=0x20 gives 0x00000010.
- Flush: at the next edge both stages are invalid, and any input offered in the flush cycle is dropped. Flush takes priority over simultaneous in/out fires. in_ready stays as computed; an accepted input is discarded.
- Reset mid-operation: all entries are discarded immediately and no stale out_valid remains.

Optional Feature:
BRU_STATS_EN:
- Defined: total_cnt increments on each output fire. taken_cnt increments on each output fire with taken=1. Both saturate at all-ones, are cleared by reset, and are unaffected by flush (only fired outputs count).
- Undefined: taken_cnt and total_cnt are tied to 0 and no counter flops exist.

Test Plan:
1. BEQ, flags=4'b0100, pc=0x100, imm=0x20, out_ready=1 -> two edges later out_valid=1, taken=1, target=0x120, illegal=0.
2. BLT with flags=4'b1000 -> taken=1. BLT with flags=4'b1001 -> taken=0, target=pc+4. BLTU with flags=4'b0010 -> taken=0. BGEU with flags=4'b0010 -> taken=1.
3. Back-pressure: out_ready=0, offer 3 back-to-back branches (pc=0x0,0x4,0x8) -> in_ready drops after 2 accepts. Then out_ready=1 -> results appear in order 0x0,0x4,0x8, with the 3rd accepted once space frees.
4. Flush with both stages full and a new in_valid -> next cycle out_valid=0, nothing from those 3 ever appears. The next branch resolves normally.
5. funct3=3'b010, pc=0x40 -> taken=0, illegal=1, target=0x44. Wrap case pc=0xFFFFFFF0, imm=0x20, BEQ Z=1 -> target=0x00000010.
6. rst_n pulsed low mid-stream (asynchronously, between edges) -> out_valid=0 immediately. With BRU_STATS_EN: 3 taken + 2 not-taken retired -> taken_cnt=3, total_cnt=5, then cleared by reset.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves RISC-V conditional branches from ALU NZCV flags in a 2-stage valid/ready pipeline
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready         upstream handshake; in_ready is independent of in_valid
//   flags, funct3, pc, imm      {N,Z,C,V} from SUB a-b, branch condition, branch PC, offset
//   flush                       synchronous kill of both stages (dropping any input this cycle)
//   out_valid / out_ready       downstream handshake
//   taken, target, illegal      resolution: target is pc+imm when taken, else pc+4
//   taken_cnt, total_cnt        retirement statistics, present only when BRU_STATS_EN is defined
//
// Build option: define BRU_STATS_EN to add saturating retirement counters; otherwise they read 0.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       flags,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [XLEN-1:0]  target,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] total_cnt
);
    logic            s1_valid_q, s1_valid_d;
    logic [3:0]      s1_flags_q;
    logic [2:0]      s1_funct3_q;
    logic [XLEN-1:0] s1_pc_q, s1_imm_q;
    logic            out_valid_q, out_valid_d;
    logic            taken_q, taken_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            s2_adv, in_fire, lt, base;

    always_comb begin
        s2_adv      = !out_valid_q || out_ready;
        in_ready    = !s1_valid_q || s2_adv;
        in_fire     = in_valid && in_ready;
        s1_valid_d  = flush ? 1'b0 : in_fire ? 1'b1 : s2_adv ? 1'b0 : s1_valid_q;
        out_valid_d = flush ? 1'b0 : s2_adv ? s1_valid_q : out_valid_q;
        // funct3[0] inverts the base condition: BEQ/BNE on Z, BLT/BGE on N^V, BLTU/BGEU on C (C=1 means a>=b unsigned).
        lt          = s1_flags_q[3] ^ s1_flags_q[0];
        base        = s1_funct3_q[2] ? (s1_funct3_q[1] ? !s1_flags_q[1] : lt) : s1_flags_q[2];
        illegal_d   = s1_funct3_q[2:1] == 2'b01;
        taken_d     = !illegal_d && (base ^ s1_funct3_q[0]);
        target_d    = s1_pc_q + (taken_d ? s1_imm_q : XLEN'(4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_flags_q  <= '0;
            s1_funct3_q <= '0;
            s1_pc_q     <= '0;
            s1_imm_q    <= '0;
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            target_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (in_fire) begin
                s1_flags_q  <= flags;
                s1_funct3_q <= funct3;
                s1_pc_q     <= pc;
                s1_imm_q    <= imm;
            end
            // Result registers only change when a real entry moves in, keeping outputs stable under back-pressure.
            if (s2_adv && s1_valid_q) begin
                taken_q   <= taken_d;
                illegal_q <= illegal_d;
                target_q  <= target_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign taken     = taken_q;
    assign illegal   = illegal_q;
    assign target    = target_q;

`ifdef BRU_STATS_EN
    logic             out_fire;
    logic [CNT_W-1:0] taken_cnt_q, total_cnt_q;

    assign out_fire = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q <= '0;
            total_cnt_q <= '0;
        end else if (out_fire) begin
            total_cnt_q <= total_cnt_q + CNT_W'(total_cnt_q != '1);
            taken_cnt_q <= taken_cnt_q + CNT_W'(taken_q && taken_cnt_q != '1);
        end
    end

    assign taken_cnt = taken_cnt_q;
    assign total_cnt = total_cnt_q;
`else
    assign taken_cnt = '0;
    assign total_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, taken, illegal;
    logic [3:0]  flags;
    logic [2:0]  funct3;
    logic [31:0] pc, imm, target;
    logic [15:0] taken_cnt, total_cnt;
    int          pass = 0;
    int          total = 0;

    branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .flags(flags), .funct3(funct3), .pc(pc), .imm(imm), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
        .target(target), .illegal(illegal), .taken_cnt(taken_cnt), .total_cnt(total_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [3:0] fl, input logic [31:0] p, input logic [31:0] im);
        in_valid = 1'b1;
        funct3   = f3;
        flags    = fl;
        pc       = p;
        imm      = im;
    endtask

    task automatic test_reset();
        #2;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass++;
        total++; if (taken !== 1'b0) $display("FAIL reset_taken got %b exp 0", taken); else pass++;
        total++; if (target !== 32'h0) $display("FAIL reset_target got %h exp 0", target); else pass++;
        total++; if (illegal !== 1'b0) $display("FAIL reset_illegal got %b exp 0", illegal); else pass++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass++;
        total++; if (total_cnt !== 16'h0 || taken_cnt !== 16'h0) $display("FAIL reset_cnt got %h/%h exp 0/0", taken_cnt, total_cnt); else pass++;
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_beq();
        out_ready = 1'b1;
        drive(3'b000, 4'b0100, 32'h100, 32'h20);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL beq_latency got out_valid %b exp 0", out_valid); else pass++;
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL beq_valid got %b exp 1", out_valid); else pass++;
        total++; if (taken !== 1'b1) $display("FAIL beq_taken got %b exp 1", taken); else pass++;
        total++; if (target !== 32'h120) $display("FAIL beq_target got %h exp 120", target); else pass++;
        total++; if (illegal !== 1'b0) $display("FAIL beq_illegal got %b exp 0", illegal); else pass++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL beq_drain got out_valid %b exp 0", out_valid); else pass++;
    endtask

    task automatic test_conditions();
        logic [2:0] f3s [7] = '{3'b100, 3'b100, 3'b110, 3'b111, 3'b001, 3'b101, 3'b000};
        logic [3:0] fls [7] = '{4'b1000, 4'b1001, 4'b0010, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
        logic       exp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(f3s[i], fls[i], 32'h200, 32'h40);
            tick();
            in_valid = 1'b0;
            tick();
            total++; if (out_valid !== 1'b1 || taken !== exp[i]) $display("FAIL cond_%0d taken got %b valid %b exp %b", i, taken, out_valid, exp[i]); else pass++;
            total++; if (target !== (exp[i] ? 32'h240 : 32'h204)) $display("FAIL cond_%0d target got %h exp %h", i, target, exp[i] ? 32'h240 : 32'h204); else pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(3'b000, 4'b0100, 32'h0, 32'h100);
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready0 got %b exp 1", in_ready); else pass++;
        tick();
        pc = 32'h4;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready1 got %b exp 1", in_ready); else pass++;
        tick();
        pc = 32'h8;
        total++; if (in_ready !== 1'b0) $display("FAIL bp_full got in_ready %b exp 0", in_ready); else pass++;
        tick();
        total++; if (in_ready !== 1'b0) $display("FAIL bp_hold got in_ready %b exp 0", in_ready); else pass++;
        total++; if (out_valid !== 1'b1 || target !== 32'h100) $display("FAIL bp_stable got %b/%h exp 1/100", out_valid, target); else pass++;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_release got in_ready %b exp 1", in_ready); else pass++;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || target !== 32'h104) $display("FAIL bp_order1 got %b/%h exp 1/104", out_valid, target); else pass++;
        tick();
        total++; if (out_valid !== 1'b1 || target !== 32'h108) $display("FAIL bp_order2 got %b/%h exp 1/108", out_valid, target); else pass++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got out_valid %b exp 0", out_valid); else pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(3'b000, 4'b0100, 32'h10, 32'h100);
        tick();
        pc = 32'h14;
        tick();
        pc    = 32'h18;
        flush = 1'b1;
        total++; if (in_ready !== 1'b0) $display("FAIL flush_full got in_ready %b exp 0", in_ready); else pass++;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) $display("FAIL flush_kill got out_valid %b exp 0", out_valid); else pass++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL flush_stale1 got out_valid %b exp 0", out_valid); else pass++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL flush_stale2 got out_valid %b exp 0", out_valid); else pass++;
        drive(3'b000, 4'b0100, 32'h30, 32'h100);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL flush_drop_in got out_valid %b exp 0", out_valid); else pass++;
        drive(3'b000, 4'b0100, 32'h30, 32'h100);
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1 || target !== 32'h130) $display("FAIL flush_after got %b/%h exp 1/130", out_valid, target); else pass++;
        tick();
    endtask

    task automatic test_illegal_wrap();
        out_ready = 1'b1;
        drive(3'b010, 4'b0100, 32'h40, 32'h20);
        tick();
        drive(3'b000, 4'b0100, 32'hFFFF_FFF0, 32'h20);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || illegal !== 1'b1 || taken !== 1'b0) $display("FAIL illegal got v%b i%b t%b exp 1 1 0", out_valid, illegal, taken); else pass++;
        total++; if (target !== 32'h44) $display("FAIL illegal_target got %h exp 44", target); else pass++;
        tick();
        total++; if (out_valid !== 1'b1 || illegal !== 1'b0 || taken !== 1'b1) $display("FAIL wrap got v%b i%b t%b exp 1 0 1", out_valid, illegal, taken); else pass++;
        total++; if (target !== 32'h10) $display("FAIL wrap_target got %h exp 10", target); else pass++;
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(3'b000, 4'b0100, 32'h50, 32'h100);
        tick();
        pc = 32'h54;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || target !== 32'h150) $display("FAIL ar_pre got %b/%h exp 1/150", out_valid, target); else pass++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || target !== 32'h0 || taken !== 1'b0) $display("FAIL ar_immediate got %b/%h/%b exp 0/0/0", out_valid, target, taken); else pass++;
        #4 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL ar_no_stale got v%b r%b exp 0 1", out_valid, in_ready); else pass++;
    endtask

    task automatic test_stats();
        logic [3:0] fls [5] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(3'b000, fls[i], 32'h80, 32'h8);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
`ifdef BRU_STATS_EN
        total++; if (taken_cnt !== 16'd3) $display("FAIL stats_taken got %0d exp 3", taken_cnt); else pass++;
        total++; if (total_cnt !== 16'd5) $display("FAIL stats_total got %0d exp 5", total_cnt); else pass++;
`else
        total++; if (taken_cnt !== 16'd0 || total_cnt !== 16'd0) $display("FAIL stats_tied got %0d/%0d exp 0/0", taken_cnt, total_cnt); else pass++;
`endif
        #2 rst_n = 1'b0;
        #1;
        total++; if (taken_cnt !== 16'd0 || total_cnt !== 16'd0) $display("FAIL stats_reset got %0d/%0d exp 0/0", taken_cnt, total_cnt); else pass++;
        #4 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        flags = '0;
        funct3 = '0;
        pc = '0;
        imm = '0;
        test_reset();
        test_beq();
        test_conditions();
        test_back_to_back();
        test_flush();
        test_illegal_wrap();
        test_async_reset();
        test_stats();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
